// File: rtl/multi_pattern_detector.sv
// ---------------------------------------------------------------------------
// multi_pattern_detector
// Serial detector for NUM_PAT runtime-programmable PAT_W-bit patterns on a
// valid-qualified single-bit stream. Matches are Mealy (same cycle as the
// final bit). Each slot has an enable and an optional non-overlap lockout.
//
// Optional feature macro: MULTI_PAT_CNT_EN
//   defined   -> per-slot saturating match counters on match_cnt
//   undefined -> no counter flops, match_cnt tied to 0
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   clear      synchronous flush of history, fill, lockouts and counters
//   in_valid   qualifies in; stream advances only when high
//   in         serial data bit
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   cfg_we     configuration write strobe
//   cfg_idx    slot being written (out-of-range writes are ignored)
//   cfg_pat    pattern value, MSB is the oldest bit
//   cfg_en     slot enable
//   match      per-slot match (combinational)
//   out        OR of match
//   match_cnt  per-slot counters, slot k at [k*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module multi_pattern_detector #(
    parameter int unsigned PAT_W   = 4,
    parameter int unsigned NUM_PAT = 2,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     in,
    input  logic                     overlap,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [PAT_W-1:0]         cfg_pat,
    input  logic                     cfg_en,
    output logic [NUM_PAT-1:0]       match,
    output logic                     out,
    output logic [NUM_PAT*CNT_W-1:0] match_cnt
);

    localparam int unsigned       FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_W-1:0]   pat  [NUM_PAT];
    logic [NUM_PAT-1:0] en;
    logic [FILL_W-1:0]  lock [NUM_PAT];
    logic [PAT_W-1:0]   window;
    logic [NUM_PAT-1:0] cfg_hit;

    assign window = {hist, in};

    // Per-slot match decode; lockout is only consulted in non-overlap mode.
    // Out-of-range cfg_idx never equals a slot index, so such writes drop.
    always_comb begin
        match   = '0;
        cfg_hit = '0;
        for (int k = 0; k < NUM_PAT; k++) begin
            match[k]   = in_valid && en[k] && (fill == FILL_MAX) &&
                         (window == pat[k]) && (overlap || (lock[k] == '0));
            cfg_hit[k] = cfg_we && (cfg_idx == IDX_W'(k));
        end
    end

    assign out = |match;

    // Shift history and saturating fill count; clear beats in_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= (PAT_W-1)'({hist, in});
            if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // Per-slot pattern, enable and lockout; a config write also clears lockout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en <= '0;
            for (int k = 0; k < NUM_PAT; k++) begin
                pat[k]  <= '0;
                lock[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PAT; k++) begin
                if (cfg_hit[k]) begin
                    pat[k]  <= cfg_pat;
                    en[k]   <= cfg_en;
                    lock[k] <= '0;
                end else if (clear) begin
                    lock[k] <= '0;
                end else if (in_valid) begin
                    if (!overlap && match[k]) begin
                        lock[k] <= FILL_MAX;
                    end else if (lock[k] != '0) begin
                        lock[k] <= lock[k] - FILL_W'(1);
                    end
                end
            end
        end
    end

`ifdef MULTI_PAT_CNT_EN
    logic [CNT_W-1:0] cnt [NUM_PAT];

    // Saturating per-slot match counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PAT; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PAT; k++) begin
                if (clear) begin
                    cnt[k] <= '0;
                end else if (match[k] && (cnt[k] != '1)) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int k = 0; k < NUM_PAT; k++) begin
            match_cnt[k*CNT_W +: CNT_W] = cnt[k];
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_multi_pattern_detector
// Table-driven directed vectors, hand sequences for multi-cycle corners, and
// a randomized phase checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_multi_pattern_detector;

    localparam int unsigned PAT_W   = 4;
    localparam int unsigned NUM_PAT = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned IDX_W   = 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clear;
    logic                     in_valid;
    logic                     in;
    logic                     overlap;
    logic                     cfg_we;
    logic [IDX_W-1:0]         cfg_idx;
    logic [PAT_W-1:0]         cfg_pat;
    logic                     cfg_en;
    logic [NUM_PAT-1:0]       match;
    logic                     out;
    logic [NUM_PAT*CNT_W-1:0] match_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    multi_pattern_detector #(
        .PAT_W   (PAT_W),
        .NUM_PAT (NUM_PAT),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in        (in),
        .overlap   (overlap),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_pat   (cfg_pat),
        .cfg_en    (cfg_en),
        .match     (match),
        .out       (out),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ov;
        bit         clr;
        bit         v;
        bit         d;
        logic [1:0] m;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit ov, bit clr, bit v, bit d, logic [1:0] m);
        vec_t r;
        r.ov = ov; r.clr = clr; r.v = v; r.d = d; r.m = m;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One stream cycle: inputs applied after the edge, outputs sampled mid-cycle.
    task automatic step(input bit v, input bit d, input bit clr, input logic [1:0] em,
                        input string nm);
        in_valid = v; in = d; clear = clr;
        #3;
        chk({nm, "_match"}, 32'(match), 32'(em));
        chk({nm, "_out"}, 32'(out), 32'(|em));
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic cfg(input logic [IDX_W-1:0] idx, input logic [PAT_W-1:0] p, input bit e);
        cfg_we = 1'b1; cfg_idx = idx; cfg_pat = p; cfg_en = e;
        in_valid = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; cfg_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            overlap = tbl[i].ov;
            step(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].m, $sformatf("%s[%0d]", nm, i));
        end
        tbl.delete();
    endtask

    function automatic logic [3:0] exp_cnt_vec(input int c0, input int c1);
`ifdef MULTI_PAT_CNT_EN
        return {2'(c1), 2'(c0)};
`else
        return 4'(c0 * 0 + c1 * 0);
`endif
    endfunction

    // Reference model: recent valid bits in a queue, lockout expressed as the
    // stream position of the last locking match per slot.
    logic [PAT_W-1:0] m_pat [NUM_PAT];
    bit               m_en  [NUM_PAT];
    bit               m_q   [$];
    int               m_last[NUM_PAT];
    int               m_vcnt;
    int               m_cnt [NUM_PAT];

    task automatic model_reset();
        m_q.delete();
        m_vcnt = 0;
        for (int k = 0; k < NUM_PAT; k++) begin
            m_pat[k] = '0; m_en[k] = 1'b0; m_last[k] = -100; m_cnt[k] = 0;
        end
    endtask

    function automatic logic [1:0] model_eval(input bit v, input bit d, input bit ov);
        logic [1:0] r;
        int         w;
        int         n;
        r = '0;
        n = m_vcnt + 1;
        if (v && m_q.size() == PAT_W - 1) begin
            w = 0;
            foreach (m_q[i]) w = w * 2 + int'(m_q[i]);
            w = w * 2 + int'(d);
            for (int k = 0; k < NUM_PAT; k++) begin
                r[k] = m_en[k] && (w == int'(m_pat[k])) && (ov || (n - m_last[k] >= PAT_W));
            end
        end
        return r;
    endfunction

    task automatic model_update(input bit v, input bit d, input bit clr, input bit ov,
                                input logic [1:0] em, input bit we, input int idx,
                                input logic [PAT_W-1:0] p, input bit e);
        if (clr) begin
            m_q.delete();
            for (int k = 0; k < NUM_PAT; k++) begin
                m_last[k] = -100; m_cnt[k] = 0;
            end
        end else if (v) begin
            m_vcnt++;
            for (int k = 0; k < NUM_PAT; k++) begin
                if (em[k] && !ov) m_last[k] = m_vcnt;
                if (em[k] && m_cnt[k] < 3) m_cnt[k]++;
            end
            m_q.push_back(d);
            if (m_q.size() > PAT_W - 1) void'(m_q.pop_front());
        end
        if (we && idx < NUM_PAT) begin
            m_pat[idx] = p; m_en[idx] = e; m_last[idx] = -100;
        end
    endtask

    logic [PAT_W-1:0] plist [6];

    initial begin
        logic [1:0] em;
        bit         rv, rd, rclr, rov, rwe, ren;
        int         ridx;
        logic [PAT_W-1:0] rp;

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in = 1'b0; overlap = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0; cfg_en = 1'b0;
        #3;
        chk("reset_match", 32'(match), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Multi-pattern stream.
        cfg(1'b0, 4'b0110, 1'b1);
        cfg(1'b1, 4'b0101, 1'b1);
        tbl.push_back(mk(1, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 2'b01));
        tbl.push_back(mk(1, 0, 1, 1, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, 2'b10));
        run_table("multi");

        // Overlap vs non-overlap on 0101.
        cfg(1'b0, 4'b0101, 1'b1);
        cfg(1'b1, 4'b0101, 1'b0);
        tbl.push_back(mk(1, 1, 0, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, 2'b01));
        tbl.push_back(mk(1, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, 2'b01));
        tbl.push_back(mk(0, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(0, 0, 1, 1, 2'b00));
        tbl.push_back(mk(0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(0, 0, 1, 1, 2'b01));
        tbl.push_back(mk(0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(0, 0, 1, 1, 2'b00));
        tbl.push_back(mk(0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(0, 0, 1, 1, 2'b01));
        run_table("overlap");

        // Fill guard after reset and after clear.
        do_reset();
        overlap = 1'b1;
        cfg(1'b0, 4'b0000, 1'b1);
        step(1, 0, 0, 2'b00, "fill1");
        step(1, 0, 0, 2'b00, "fill2");
        step(1, 0, 0, 2'b00, "fill3");
        step(1, 0, 0, 2'b01, "fill4");
        step(0, 0, 1, 2'b00, "fill_clr");
        step(1, 0, 0, 2'b00, "fillc1");
        step(1, 0, 0, 2'b00, "fillc2");
        step(1, 0, 0, 2'b00, "fillc3");

        // Valid gaps, then config write in the match cycle.
        do_reset();
        cfg(1'b0, 4'b0110, 1'b1);
        step(1, 0, 0, 2'b00, "gap_v1");
        step(0, 1, 0, 2'b00, "gap_i1");
        step(1, 1, 0, 2'b00, "gap_v2");
        step(0, 1, 0, 2'b00, "gap_i2");
        step(1, 1, 0, 2'b00, "gap_v3");
        step(0, 1, 0, 2'b00, "gap_i3");
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_pat = 4'b1111; cfg_en = 1'b1;
        step(1, 0, 0, 2'b01, "gap_v4_cfg");
        cfg_we = 1'b0;
        step(1, 1, 0, 2'b00, "newpat1");
        step(1, 1, 0, 2'b00, "newpat2");
        step(1, 1, 0, 2'b00, "newpat3");
        step(1, 1, 0, 2'b01, "newpat4");

        // Async reset mid-stream.
        do_reset();
        cfg(1'b0, 4'b0110, 1'b1);
        step(1, 0, 0, 2'b00, "ar1");
        step(1, 1, 0, 2'b00, "ar2");
        step(1, 1, 0, 2'b00, "ar3");
        in_valid = 1'b1; in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_match", 32'(match), 32'd0);
        chk("ar_out", 32'(out), 32'd0);
        chk("ar_cnt", 32'(match_cnt), 32'd0);
        chk("ar_hist", 32'(dut.hist), 32'd0);
        chk("ar_en", 32'(dut.en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        cfg(1'b0, 4'b0110, 1'b1);
        step(1, 0, 0, 2'b00, "ar_after");

        // Counter saturation on slot 0.
        do_reset();
        overlap = 1'b1;
        cfg(1'b0, 4'b0000, 1'b1);
        step(1, 0, 0, 2'b00, "cnt_f1");
        step(1, 0, 0, 2'b00, "cnt_f2");
        step(1, 0, 0, 2'b00, "cnt_f3");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 2'b01, $sformatf("cnt_m%0d", i));
            chk($sformatf("cnt_val%0d", i), 32'(match_cnt),
                32'(exp_cnt_vec((i + 1 > 3) ? 3 : i + 1, 0)));
        end

        // Randomized stream against the reference model.
        plist[0] = 4'b0110; plist[1] = 4'b0101; plist[2] = 4'b0000;
        plist[3] = 4'b1111; plist[4] = 4'b1010; plist[5] = 4'b0011;
        do_reset();
        model_reset();
        rov = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rv   = ($urandom_range(3, 0) != 0);
            rd   = 1'($urandom_range(1, 0));
            rclr = ($urandom_range(39, 0) == 0);
            if ($urandom_range(15, 0) == 0) rov = ~rov;
            rwe  = ($urandom_range(11, 0) == 0);
            ridx = int'($urandom_range(1, 0));
            rp   = ($urandom_range(3, 0) == 0) ? PAT_W'($urandom) : plist[$urandom_range(5, 0)];
            ren  = ($urandom_range(3, 0) != 0);
            em   = model_eval(rv, rd, rov);
            in_valid = rv; in = rd; clear = rclr; overlap = rov;
            cfg_we = rwe; cfg_idx = IDX_W'(ridx); cfg_pat = rp; cfg_en = ren;
            #3;
            chk($sformatf("rnd%0d_match", i), 32'(match), 32'(em));
            chk($sformatf("rnd%0d_out", i), 32'(out), 32'(|em));
            chk($sformatf("rnd%0d_cnt", i), 32'(match_cnt), 32'(exp_cnt_vec(m_cnt[0], m_cnt[1])));
            model_update(rv, rd, rclr, rov, em, rwe, ridx, rp, ren);
            @(posedge clk); #1;
        end
        cfg_we = 1'b0; in_valid = 1'b0; clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
